// File: rtl/config_stream_loader.sv
// Byte-stream to tile configuration bus loader: frames sync/address/data records
// and presents each one on the broadcast config bus for a fixed hold window.
module config_stream_loader #(
   parameter logic [7:0]  SYNC_BYTE   = 8'hC5,
   parameter logic [31:0] IDLE_ADDR   = 32'hFFFF_FFFF,
   parameter logic [31:0] END_ADDR    = 32'hFFFF_FFFE,
   parameter int unsigned HOLD_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] config_addr,
   output logic [31:0] config_data,
   output logic        busy,
   output logic        config_done,
   output logic [15:0] records_loaded,
   output logic [7:0]  sync_errors
);

   localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADDR  = 2'd1,
      DATA  = 2'd2,
      DRIVE = 2'd3
   } state_t;

   state_t            state_r;
   state_t            state_nx_s;
   logic [1:0]        byte_idx_r;
   logic [HOLD_W-1:0] hold_cnt_r;
   logic [31:0]       shadow_addr_r;
   logic [31:0]       shadow_data_r;
   logic [31:0]       config_addr_r;
   logic [31:0]       config_data_r;
   logic              config_done_r;
   logic [15:0]       records_loaded_r;
   logic [7:0]        sync_errors_r;

   logic              in_ready_s;
   logic              xfer_s;
   logic              last_byte_s;
   logic              hold_last_s;
   logic              is_end_s;

   // Acceptance depends on state only, so a stalled host never sees ready chatter.
   assign in_ready_s  = (state_r != DRIVE);
   assign xfer_s      = in_valid && in_ready_s;
   assign last_byte_s = (byte_idx_r == 2'd3);
   assign hold_last_s = (hold_cnt_r == HOLD_LAST);
   assign is_end_s    = (shadow_addr_r == END_ADDR);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (xfer_s && (in_data == SYNC_BYTE)) begin
               state_nx_s = ADDR;
            end else begin
               state_nx_s = IDLE;
            end
         end
         ADDR: begin
            if (xfer_s && last_byte_s) begin
               state_nx_s = DATA;
            end else begin
               state_nx_s = ADDR;
            end
         end
         DATA: begin
            if (xfer_s && last_byte_s) begin
               state_nx_s = is_end_s ? IDLE : DRIVE;
            end else begin
               state_nx_s = DATA;
            end
         end
         DRIVE: begin
            if (hold_last_s) begin
               state_nx_s = IDLE;
            end else begin
               state_nx_s = DRIVE;
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // Record assembly, bus presentation and host-visible counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         byte_idx_r       <= 2'd0;
         hold_cnt_r       <= '0;
         shadow_addr_r    <= 32'd0;
         shadow_data_r    <= 32'd0;
         config_addr_r    <= IDLE_ADDR;
         config_data_r    <= 32'd0;
         config_done_r    <= 1'b0;
         records_loaded_r <= 16'd0;
         sync_errors_r    <= 8'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (xfer_s) begin
                  if (in_data == SYNC_BYTE) begin
                     byte_idx_r <= 2'd0;
                  end else if (sync_errors_r != 8'hFF) begin
                     sync_errors_r <= sync_errors_r + 8'd1;
                  end
               end
            end
            ADDR: begin
               // Little-endian shift-in: after four bytes the first one sits in [7:0].
               if (xfer_s) begin
                  shadow_addr_r <= {in_data, shadow_addr_r[31:8]};
                  byte_idx_r    <= byte_idx_r + 2'd1;
               end
            end
            DATA: begin
               if (xfer_s) begin
                  shadow_data_r <= {in_data, shadow_data_r[31:8]};
                  byte_idx_r    <= byte_idx_r + 2'd1;
                  if (last_byte_s) begin
                     if (is_end_s) begin
                        config_done_r <= 1'b1;
                     end else begin
                        config_addr_r <= shadow_addr_r;
                        config_data_r <= {in_data, shadow_data_r[31:8]};
                        hold_cnt_r    <= '0;
                     end
                  end
               end
            end
            DRIVE: begin
               if (hold_last_s) begin
                  config_addr_r <= IDLE_ADDR;
                  config_data_r <= 32'd0;
                  hold_cnt_r    <= '0;
                  if (records_loaded_r != 16'hFFFF) begin
                     records_loaded_r <= records_loaded_r + 16'd1;
                  end
               end else begin
                  hold_cnt_r <= hold_cnt_r + {{(HOLD_W-1){1'b0}}, 1'b1};
               end
            end
            default: begin
               config_addr_r <= IDLE_ADDR;
               config_data_r <= 32'd0;
               byte_idx_r    <= 2'd0;
               hold_cnt_r    <= '0;
            end
         endcase
      end
   end

   assign in_ready       = in_ready_s;
   assign busy           = (state_r != IDLE);
   assign config_addr    = config_addr_r;
   assign config_data    = config_data_r;
   assign config_done    = config_done_r;
   assign records_loaded = records_loaded_r;
   assign sync_errors    = sync_errors_r;

endmodule

// File: tb/tb_config_stream_loader.sv
// Directed self-checking bench for config_stream_loader (HOLD_CYCLES = 2).
module tb_config_stream_loader;

   logic        clk;
   logic        reset;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] config_addr;
   logic [31:0] config_data;
   logic        busy;
   logic        config_done;
   logic [15:0] records_loaded;
   logic [7:0]  sync_errors;

   int total = 0;
   int bad   = 0;
   int w0;
   int wtmp;

   config_stream_loader dut (
      .clk            (clk),
      .reset          (reset),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .config_addr    (config_addr),
      .config_data    (config_data),
      .busy           (busy),
      .config_done    (config_done),
      .records_loaded (records_loaded),
      .sync_errors    (sync_errors)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_counters(input logic [15:0] rec, input logic [7:0] serr, input logic done);
      check("records_loaded", {16'd0, records_loaded}, {16'd0, rec});
      check("sync_errors", {24'd0, sync_errors}, {24'd0, serr});
      check("config_done", {31'd0, config_done}, {31'd0, done});
   endtask

   // Offer one byte, waiting (bounded) for in_ready, and consume the transfer edge.
   task automatic send_byte(input logic [7:0] b, output int waits);
      waits    = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && waits < 20) begin
         @(posedge clk); #1;
         waits++;
      end
      check("ready_wait", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic send_record(input logic [31:0] addr, input logic [31:0] data,
                              input bit gap, output int sync_waits);
      logic [7:0] bytes [9];
      int w;
      bytes[0] = 8'hC5;
      for (int i = 0; i < 4; i++) begin
         bytes[1+i] = addr[8*i +: 8];
         bytes[5+i] = data[8*i +: 8];
      end
      sync_waits = 0;
      for (int i = 0; i < 9; i++) begin
         if (gap) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
            check("gap_addr", config_addr, 32'hFFFF_FFFF);
         end
         send_byte(bytes[i], w);
         if (i == 0) sync_waits = w;
         if (i < 8) check("asm_addr", config_addr, 32'hFFFF_FFFF);
      end
      in_valid = 1'b0;
   endtask

   // Called right after the last data byte's edge: two hold cycles, then idle bus.
   task automatic check_drive(input logic [31:0] addr, input logic [31:0] data);
      in_valid = 1'b0;
      for (int c = 0; c < 2; c++) begin
         check("drive_addr", config_addr, addr);
         check("drive_data", config_data, data);
         check("drive_ready", {31'd0, in_ready}, 32'd0);
         check("drive_busy", {31'd0, busy}, 32'd1);
         @(posedge clk); #1;
      end
      check("post_addr", config_addr, 32'hFFFF_FFFF);
      check("post_data", config_data, 32'd0);
      check("post_ready", {31'd0, in_ready}, 32'd1);
      check("post_busy", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_addr", config_addr, 32'hFFFF_FFFF);
      check("rst_data", config_data, 32'd0);
      check("rst_ready", {31'd0, in_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check_counters(16'd0, 8'd0, 1'b0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Basic record, continuous valid.
      send_record(32'h0002_0001, 32'hDEAD_BEEF, 1'b0, w0);
      check_drive(32'h0002_0001, 32'hDEAD_BEEF);
      check_counters(16'd1, 8'd0, 1'b0);

      // Two junk bytes then a record.
      send_byte(8'h00, wtmp);
      send_byte(8'h12, wtmp);
      in_valid = 1'b0;
      check("junk_busy", {31'd0, busy}, 32'd0);
      check_counters(16'd1, 8'd2, 1'b0);
      send_record(32'h0002_0001, 32'hDEAD_BEEF, 1'b0, w0);
      check_drive(32'h0002_0001, 32'hDEAD_BEEF);
      check_counters(16'd2, 8'd2, 1'b0);

      // Sync error saturation (300 junk bytes overall).
      for (int i = 0; i < 253; i++) send_byte(8'h00, wtmp);
      in_valid = 1'b0;
      check_counters(16'd2, 8'd255, 1'b0);
      for (int i = 0; i < 47; i++) send_byte(8'h00, wtmp);
      in_valid = 1'b0;
      check_counters(16'd2, 8'd255, 1'b0);

      // Same record with in_valid toggling.
      send_record(32'h0002_0001, 32'hDEAD_BEEF, 1'b1, w0);
      check_drive(32'h0002_0001, 32'hDEAD_BEEF);
      check_counters(16'd3, 8'd255, 1'b0);

      // END record: no bus activity, config_done sticky.
      send_record(32'hFFFF_FFFE, 32'h0000_0000, 1'b0, w0);
      check("end_addr", config_addr, 32'hFFFF_FFFF);
      check("end_busy", {31'd0, busy}, 32'd0);
      check("end_ready", {31'd0, in_ready}, 32'd1);
      check_counters(16'd3, 8'd255, 1'b1);
      @(posedge clk); #1;
      check("end_addr2", config_addr, 32'hFFFF_FFFF);
      send_record(32'h1234_5678, 32'hA5A5_0F0F, 1'b0, w0);
      check_drive(32'h1234_5678, 32'hA5A5_0F0F);
      check_counters(16'd4, 8'd255, 1'b1);

      // Back-to-back records with valid held high.
      send_record(32'h0003_0004, 32'h1122_3344, 1'b0, w0);
      check("b2b_first_addr", config_addr, 32'h0003_0004);
      send_record(32'h0005_0006, 32'h5566_7788, 1'b0, w0);
      check("b2b_sync_waits", w0, 32'd2);
      check_drive(32'h0005_0006, 32'h5566_7788);
      check_counters(16'd6, 8'd255, 1'b1);

      // Asynchronous reset in the middle of the address field.
      send_byte(8'hC5, wtmp);
      send_byte(8'h11, wtmp);
      send_byte(8'h22, wtmp);
      send_byte(8'h33, wtmp);
      in_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check("arst_addr", config_addr, 32'hFFFF_FFFF);
      check("arst_data", config_data, 32'd0);
      check("arst_ready", {31'd0, in_ready}, 32'd1);
      check("arst_busy", {31'd0, busy}, 32'd0);
      check_counters(16'd0, 8'd0, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      send_record(32'h00AB_00CD, 32'h0BAD_F00D, 1'b0, w0);
      check_drive(32'h00AB_00CD, 32'h0BAD_F00D);
      check_counters(16'd1, 8'd0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
